// File: rtl/score_counter_multi.sv
// Multi-channel score counter: async up/down button levels are synchronised and
// edge-detected, then each channel counts within [0, MAX_VAL] with clear, load and freeze.
module score_counter_multi #(
    parameter int NUM_CH  = 2,
    parameter int BW      = 7,
    parameter int MAX_VAL = 99,
    parameter int WRAP    = 0,
    parameter int LCH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_CH-1:0]    up_i,
    input  logic [NUM_CH-1:0]    down_i,
    input  logic                 clr_i,
    input  logic                 freeze_i,
    input  logic                 load_i,
    input  logic [LCH_W-1:0]     load_ch_i,
    input  logic [BW-1:0]        load_val_i,
    output logic [NUM_CH*BW-1:0] counter_val_o,
    output logic [NUM_CH-1:0]    at_max_o,
    output logic [NUM_CH-1:0]    at_min_o,
    output logic [NUM_CH-1:0]    limit_hit_o
);

    localparam logic [BW-1:0] MAX_V   = BW'(MAX_VAL);
    localparam logic [BW-1:0] ZERO_V  = {BW{1'b0}};
    localparam logic [BW-1:0] ONE_V   = BW'(1'b1);
    localparam logic          WRAP_EN = (WRAP != 32'sd0);

    // Result packs {limit_hit, next_value} for one channel's button pulses.
    function automatic logic [BW:0] step_count(
        input logic [BW-1:0] val,
        input logic          up_p,
        input logic          dn_p
    );
        logic [BW:0] res;
        res = {1'b0, val};
        case ({up_p, dn_p})
            2'b10: begin
                if (val < MAX_V) begin
                    res = {1'b0, val + ONE_V};
                end else if (WRAP_EN) begin
                    res = {1'b0, ZERO_V};
                end else begin
                    res = {1'b1, val};
                end
            end
            2'b01: begin
                if (val > ZERO_V) begin
                    res = {1'b0, val - ONE_V};
                end else if (WRAP_EN) begin
                    res = {1'b0, MAX_V};
                end else begin
                    res = {1'b1, val};
                end
            end
            default: res = {1'b0, val};
        endcase
        return res;
    endfunction

    function automatic logic [BW-1:0] clamp_load(input logic [BW-1:0] val);
        logic [BW-1:0] res;
        if (val > MAX_V) begin
            res = MAX_V;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [NUM_CH-1:0]         up_s1_r, up_s2_r, up_s3_r;
    logic [NUM_CH-1:0]         dn_s1_r, dn_s2_r, dn_s3_r;
    logic [NUM_CH-1:0]         up_pulse_s, dn_pulse_s;
    logic [NUM_CH-1:0][BW-1:0] cnt_r, cnt_nxt_s;
    logic [NUM_CH-1:0][BW:0]   step_s;
    logic [NUM_CH-1:0]         hit_r, hit_nxt_s;

    // Synchroniser and delay flops reset high so a button held through reset never counts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            up_s1_r <= {NUM_CH{1'b1}};
            up_s2_r <= {NUM_CH{1'b1}};
            up_s3_r <= {NUM_CH{1'b1}};
            dn_s1_r <= {NUM_CH{1'b1}};
            dn_s2_r <= {NUM_CH{1'b1}};
            dn_s3_r <= {NUM_CH{1'b1}};
        end else begin
            up_s1_r <= up_i;
            up_s2_r <= up_s1_r;
            up_s3_r <= up_s2_r;
            dn_s1_r <= down_i;
            dn_s2_r <= dn_s1_r;
            dn_s3_r <= dn_s2_r;
        end
    end

    assign up_pulse_s = up_s2_r & ~up_s3_r;
    assign dn_pulse_s = dn_s2_r & ~dn_s3_r;

    // Per-channel next value: clear, then load, then freeze, then button pulses.
    always_comb begin
        cnt_nxt_s = cnt_r;
        hit_nxt_s = {NUM_CH{1'b0}};
        step_s    = {(NUM_CH*(BW+1)){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            step_s[c] = step_count(cnt_r[c], up_pulse_s[c], dn_pulse_s[c]);
            if (clr_i) begin
                cnt_nxt_s[c] = ZERO_V;
            end else if (load_i && (load_ch_i == LCH_W'(c))) begin
                cnt_nxt_s[c] = clamp_load(load_val_i);
            end else if (freeze_i) begin
                cnt_nxt_s[c] = cnt_r[c];
            end else begin
                cnt_nxt_s[c] = step_s[c][BW-1:0];
                hit_nxt_s[c] = step_s[c][BW];
            end
        end
    end

    // Counter and limit-hit registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= {(NUM_CH*BW){1'b0}};
            hit_r <= {NUM_CH{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
            hit_r <= hit_nxt_s;
        end
    end

    // Limit flags decode straight from the counter registers.
    always_comb begin
        at_max_o = {NUM_CH{1'b0}};
        at_min_o = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            at_max_o[c] = (cnt_r[c] == MAX_V);
            at_min_o[c] = (cnt_r[c] == ZERO_V);
        end
    end

    assign counter_val_o = cnt_r;
    assign limit_hit_o   = hit_r;

endmodule

// File: tb/tb_score_counter_multi.sv
// Bench for score_counter_multi: saturating and wrapping instances share stimulus and
// are compared against a cycle-level behavioural model of the counting rules.
`timescale 1ns/1ps
module tb_score_counter_multi;

    localparam int NUM_CH  = 2;
    localparam int BW      = 7;
    localparam int MAX_VAL = 99;
    localparam int LCH_W   = 2;
    localparam int OW      = NUM_CH*BW + 3*NUM_CH;
    localparam logic [OW-1:0] RST_VEC = {14'd0, 2'b00, 2'b11, 2'b00};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NUM_CH-1:0] up = '0, down = '0;
    logic              clr = 1'b0, freeze = 1'b0, load = 1'b0;
    logic [LCH_W-1:0]  load_ch = '0;
    logic [BW-1:0]     load_val = '0;
    logic [NUM_CH*BW-1:0] cv_sat, cv_wrp;
    logic [NUM_CH-1:0] amax_sat, amin_sat, lh_sat, amax_wrp, amin_wrp, lh_wrp;
    int errors = 0;
    int checks = 0;
    int hits_sat [NUM_CH] = '{0, 0};

    always #5 clk = ~clk;

    score_counter_multi #(.NUM_CH(NUM_CH), .BW(BW), .MAX_VAL(MAX_VAL), .WRAP(0), .LCH_W(LCH_W)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .up_i(up), .down_i(down), .clr_i(clr),
        .freeze_i(freeze), .load_i(load), .load_ch_i(load_ch), .load_val_i(load_val),
        .counter_val_o(cv_sat), .at_max_o(amax_sat), .at_min_o(amin_sat), .limit_hit_o(lh_sat));

    score_counter_multi #(.NUM_CH(NUM_CH), .BW(BW), .MAX_VAL(MAX_VAL), .WRAP(1), .LCH_W(LCH_W)) dut_wrp (
        .clk_i(clk), .rst_n_i(rst_n), .up_i(up), .down_i(down), .clr_i(clr),
        .freeze_i(freeze), .load_i(load), .load_ch_i(load_ch), .load_val_i(load_val),
        .counter_val_o(cv_wrp), .at_max_o(amax_wrp), .at_min_o(amin_wrp), .limit_hit_o(lh_wrp));

    wire [OW-1:0] obs_sat = {cv_sat, amax_sat, amin_sat, lh_sat};
    wire [OW-1:0] obs_wrp = {cv_wrp, amax_wrp, amin_wrp, lh_wrp};

    // Behavioural model: index 0 saturates, index 1 wraps. A press counts on the
    // edge two clocks after the first clock that samples the new high level.
    int       m_cnt [2][NUM_CH];
    bit       m_hit [2][NUM_CH];
    bit [2:0] up_h [NUM_CH];
    bit [2:0] dn_h [NUM_CH];

    always @(posedge clk or negedge rst_n) begin : model
        bit ue, de;
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                up_h[c] = 3'b111;
                dn_h[c] = 3'b111;
                for (int w = 0; w < 2; w++) begin
                    m_cnt[w][c] = 0;
                    m_hit[w][c] = 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                ue = up_h[c][1] && !up_h[c][2];
                de = dn_h[c][1] && !dn_h[c][2];
                for (int w = 0; w < 2; w++) begin
                    m_hit[w][c] = 1'b0;
                    if (clr) begin
                        m_cnt[w][c] = 0;
                    end else if (load && int'(load_ch) == c) begin
                        m_cnt[w][c] = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
                    end else if (!freeze && ue && !de) begin
                        if (m_cnt[w][c] < MAX_VAL) m_cnt[w][c] = m_cnt[w][c] + 1;
                        else if (w == 1) m_cnt[w][c] = 0;
                        else m_hit[w][c] = 1'b1;
                    end else if (!freeze && de && !ue) begin
                        if (m_cnt[w][c] > 0) m_cnt[w][c] = m_cnt[w][c] - 1;
                        else if (w == 1) m_cnt[w][c] = MAX_VAL;
                        else m_hit[w][c] = 1'b1;
                    end
                end
                up_h[c] = {up_h[c][1:0], up[c]};
                dn_h[c] = {dn_h[c][1:0], down[c]};
            end
        end
    end

    function automatic logic [OW-1:0] exp_vec(input int w);
        logic [NUM_CH*BW-1:0] v;
        logic [NUM_CH-1:0]    mx, mn, h;
        for (int c = 0; c < NUM_CH; c++) begin
            v[c*BW +: BW] = BW'(m_cnt[w][c]);
            mx[c] = (m_cnt[w][c] == MAX_VAL);
            mn[c] = (m_cnt[w][c] == 0);
            h[c]  = m_hit[w][c];
        end
        return {v, mx, mn, h};
    endfunction

    // Counts limit-hit pulses seen on the saturating instance.
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) if (lh_sat[c] === 1'b1) hits_sat[c]++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int c, input bit is_up);
        if (is_up) up[c] = 1'b1; else down[c] = 1'b1;
        tick(2);
        if (is_up) up[c] = 1'b0; else down[c] = 1'b0;
        tick(3);
    endtask

    task automatic do_load(input int ch, input int val);
        load = 1'b1; load_ch = LCH_W'(ch); load_val = BW'(val);
        tick(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (obs_sat !== RST_VEC) begin errors++; $display("FAIL reset_sat: got %h expected %h", obs_sat, RST_VEC); end
        checks++; if (obs_wrp !== RST_VEC) begin errors++; $display("FAIL reset_wrp: got %h expected %h", obs_wrp, RST_VEC); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        up[0] = 1'b1;
        tick(2);
        checks++; if (cv_sat[6:0] !== 7'd0) begin errors++; $display("FAIL latency_early: got %0d expected 0", cv_sat[6:0]); end
        tick(1);
        checks++; if (cv_sat[6:0] !== 7'd1) begin errors++; $display("FAIL latency_edge3: got %0d expected 1", cv_sat[6:0]); end
        up[0] = 1'b0;
        tick(3);
        checks++; if (cv_sat !== {7'd0, 7'd1}) begin errors++; $display("FAIL latency_hold: got %h expected %h", cv_sat, {7'd0, 7'd1}); end
        checks++; if (amin_sat !== 2'b10) begin errors++; $display("FAIL latency_at_min: got %b expected 10", amin_sat); end
        checks++; if (obs_wrp !== exp_vec(1)) begin errors++; $display("FAIL latency_wrp: got %h expected %h", obs_wrp, exp_vec(1)); end
    endtask

    task automatic test_saturate();
        int h0;
        int exp_sat [3] = '{99, 99, 99};
        int exp_wrp [3] = '{99, 0, 1};
        do_load(1, 98);
        h0 = hits_sat[1];
        for (int i = 0; i < 3; i++) begin
            press(1, 1'b1);
            checks++; if (int'(cv_sat[13:7]) !== exp_sat[i]) begin errors++; $display("FAIL sat_press%0d: got %0d expected %0d", i, cv_sat[13:7], exp_sat[i]); end
            checks++; if (int'(cv_wrp[13:7]) !== exp_wrp[i]) begin errors++; $display("FAIL wrp_press%0d: got %0d expected %0d", i, cv_wrp[13:7], exp_wrp[i]); end
        end
        checks++; if (hits_sat[1] - h0 !== 2) begin errors++; $display("FAIL sat_hit_count: got %0d expected 2", hits_sat[1] - h0); end
        checks++; if (amax_sat[1] !== 1'b1) begin errors++; $display("FAIL sat_at_max: got %b expected 1", amax_sat[1]); end
        checks++; if (obs_sat !== exp_vec(0)) begin errors++; $display("FAIL sat_model: got %h expected %h", obs_sat, exp_vec(0)); end
    endtask

    task automatic test_wrap();
        int h0;
        clr = 1'b1; tick(1); clr = 1'b0;
        h0 = hits_sat[0];
        press(0, 1'b0);
        checks++; if (cv_wrp[6:0] !== 7'd99) begin errors++; $display("FAIL wrap_down: got %0d expected 99", cv_wrp[6:0]); end
        checks++; if (cv_sat[6:0] !== 7'd0) begin errors++; $display("FAIL sat_floor: got %0d expected 0", cv_sat[6:0]); end
        checks++; if (hits_sat[0] - h0 !== 1) begin errors++; $display("FAIL sat_floor_hit: got %0d expected 1", hits_sat[0] - h0); end
        press(0, 1'b1);
        checks++; if (cv_wrp[6:0] !== 7'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", cv_wrp[6:0]); end
        checks++; if (obs_wrp !== exp_vec(1)) begin errors++; $display("FAIL wrap_model: got %h expected %h", obs_wrp, exp_vec(1)); end
    endtask

    task automatic test_simultaneous();
        do_load(0, 50);
        do_load(1, 7);
        up = 2'b11; down = 2'b01;
        tick(2);
        up = 2'b00; down = 2'b00;
        tick(3);
        checks++; if (cv_sat !== {7'd8, 7'd50}) begin errors++; $display("FAIL simul_sat: got %h expected %h", cv_sat, {7'd8, 7'd50}); end
        checks++; if (obs_wrp !== exp_vec(1)) begin errors++; $display("FAIL simul_wrp: got %h expected %h", obs_wrp, exp_vec(1)); end
    endtask

    task automatic test_freeze();
        freeze = 1'b1; up[0] = 1'b1;
        tick(4);
        freeze = 1'b0;
        tick(4);
        checks++; if (cv_sat[6:0] !== 7'd50) begin errors++; $display("FAIL freeze_hold: got %0d expected 50", cv_sat[6:0]); end
        up[0] = 1'b0;
        tick(2);
        press(0, 1'b1);
        checks++; if (cv_sat[6:0] !== 7'd51) begin errors++; $display("FAIL freeze_after: got %0d expected 51", cv_sat[6:0]); end
        checks++; if (obs_wrp !== exp_vec(1)) begin errors++; $display("FAIL freeze_wrp: got %h expected %h", obs_wrp, exp_vec(1)); end
    endtask

    task automatic test_reset_hold();
        up[0] = 1'b1;
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        checks++; if (cv_sat !== 14'd0) begin errors++; $display("FAIL held_reset_sat: got %h expected 0", cv_sat); end
        up[0] = 1'b0;
        tick(3);
        checks++; if (cv_wrp !== 14'd0) begin errors++; $display("FAIL held_reset_wrp: got %h expected 0", cv_wrp); end
    endtask

    task automatic test_load_clr();
        do_load(0, 120);
        checks++; if (cv_sat[6:0] !== 7'd99) begin errors++; $display("FAIL load_clamp: got %0d expected 99", cv_sat[6:0]); end
        do_load(3, 5);
        do_load(2, 6);
        checks++; if (cv_sat !== {7'd0, 7'd99}) begin errors++; $display("FAIL load_bad_ch: got %h expected %h", cv_sat, {7'd0, 7'd99}); end
        clr = 1'b1; load = 1'b1; load_ch = 2'd1; load_val = 7'd40;
        tick(1);
        clr = 1'b0; load = 1'b0;
        checks++; if (obs_sat !== RST_VEC) begin errors++; $display("FAIL clr_over_load: got %h expected %h", obs_sat, RST_VEC); end
    endtask

    task automatic test_async_reset();
        do_load(0, 33);
        do_load(1, 44);
        checks++; if (cv_wrp !== {7'd44, 7'd33}) begin errors++; $display("FAIL pre_reset: got %h expected %h", cv_wrp, {7'd44, 7'd33}); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (obs_sat !== RST_VEC) begin errors++; $display("FAIL async_rst_sat: got %h expected %h", obs_sat, RST_VEC); end
        checks++; if (obs_wrp !== RST_VEC) begin errors++; $display("FAIL async_rst_wrp: got %h expected %h", obs_wrp, RST_VEC); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_random();
        int vals [5] = '{0, 1, 98, 99, 0};
        for (int i = 0; i < 1500; i++) begin
            checks++; if (obs_sat !== exp_vec(0)) begin errors++; $display("FAIL rand_sat cyc %0d: got %h expected %h", i, obs_sat, exp_vec(0)); end
            checks++; if (obs_wrp !== exp_vec(1)) begin errors++; $display("FAIL rand_wrp cyc %0d: got %h expected %h", i, obs_wrp, exp_vec(1)); end
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0) up[c] = ~up[c];
                if ($urandom_range(0, 3) == 0) down[c] = ~down[c];
            end
            clr  = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 11) == 0);
            load_ch = LCH_W'($urandom_range(0, 3));
            vals[4] = $urandom_range(0, 127);
            load_val = BW'(vals[$urandom_range(0, 4)]);
            if ($urandom_range(0, 9) == 0) freeze = ~freeze;
            tick(1);
        end
        up = '0; down = '0; clr = 1'b0; load = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_saturate();
        test_wrap();
        test_simultaneous();
        test_freeze();
        test_reset_hold();
        test_load_clr();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_counter_multi.md
Name: score_counter_multi

Overview:
- Parametrised multi-channel score counter: next generation of the scoreboard up/down counter.
- Runs on one system clock instead of clocking the register from button signals.
- Each channel takes already-debounced, asynchronous up/down button levels and adds the following per channel:
  - synchronisation and rising-edge detection;
  - saturating or wrapping limits;
  - synchronous clear, freeze and direct load.
- Sits between the debouncers and the BCD/7-segment display path; one channel per team.

Parameters:
- NUM_CH, 2: number of independent counter channels (>=1).
- BW, 7: counter width per channel in bits.
- MAX_VAL, 99: upper count limit. Must satisfy MAX_VAL <= 2**BW-1; lower limit is fixed at 0.
- WRAP, 0: 0 = saturate at limits; 1 = wrap MAX_VAL<->0.
- LCH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1): width of load_ch_i.

Ports:
- clk_i, input, 1: system clock; all state on its rising edge.
- rst_n_i, input, 1: asynchronous active-low reset.
- up_i, input, NUM_CH: async button level per channel; a rising edge requests +1.
- down_i, input, NUM_CH: async button level per channel; a rising edge requests -1.
- clr_i, input, 1: synchronous clear of all channels to 0.
- freeze_i, input, 1: while high, button edges are discarded.
- load_i, input, 1: one-cycle load strobe.
- load_ch_i, input, LCH_W: channel index for load.
- load_val_i, input, BW: value to load.
- counter_val_o, output, NUM_CH*BW: channel c occupies bits [c*BW +: BW].
- at_max_o, output, NUM_CH: channel value == MAX_VAL.
- at_min_o, output, NUM_CH: channel value == 0.
- limit_hit_o, output, NUM_CH: one-cycle pulse when a saturating edge is ignored.

Behaviour:
- Reset (rst_n_i low, asynchronous): all counters = 0. All synchroniser and previous-value flops = 1. limit_hit_o = 0.
  - Consequence: at_min_o = all 1s, at_max_o = all 0s.
  - A button held through reset release produces no count; it must be released and pressed again.
- Input path per button: 2-flop synchroniser (s1, s2), then delay flop s3. Edge pulse = s2 & ~s3.
- Latency: up_i rising before clock edge k gives s1 at k, s2 at k+1, pulse in the following cycle. counter_val_o updates at edge k+2, i.e. visible after the third rising edge counting k as the first.
- Exactly one count per rising edge; a held level never repeats.
- Per-channel update priority each cycle, highest first:
  1. clr_i: all channels -> 0. Edges discarded, no limit_hit.
  2. load_i with load_ch_i == c: channel c <- min(load_val_i, MAX_VAL).
     - Edges on c are discarded this cycle.
     - Other channels process edges normally.
     - load_ch_i >= NUM_CH: load ignored.
  3. freeze_i: hold value; edges discarded, not queued; no limit_hit.
  4. Up pulse and down pulse both present in the same cycle: no change, no limit_hit.
  5. Up pulse only:
     - value < MAX_VAL: +1;
     - value == MAX_VAL, WRAP=1: -> 0;
     - value == MAX_VAL, WRAP=0: hold, limit_hit_o[c] = 1 for one cycle.
  6. Down pulse only:
     - value > 0: -1;
     - value == 0, WRAP=1: -> MAX_VAL;
     - value == 0, WRAP=0: hold, limit_hit_o[c] = 1 for one cycle.
- Arithmetic is BW-bit. Values > MAX_VAL are never stored.
- at_max_o and at_min_o are combinational from the counter registers. limit_hit_o is registered, asserted the cycle after the ignored pulse.
- Synchroniser flops keep running during clr/load/freeze, so an edge seen during freeze is consumed, not replayed later.
- Reset asserted mid-operation clears immediately regardless of clock.

Test Plan:
- Reset, then one up_i[0] pulse of 3 cycles -> counter 0 = 1 exactly 3 edges after the rise; channel 1 = 0; at_min_o = 2'b10.
- WRAP=0: load channel 1 with 98, then 3 up pulses -> 99, 99, 99; at_max_o[1] = 1; limit_hit_o[1] pulses once each for pulses 2 and 3.
- WRAP=1: channel 0 at 0, down pulse -> 99; then up pulse -> 0.
- Simultaneous up_i[0] and down_i[0] rise at value 50 -> stays 50. Same cycle up_i[1] at 7 -> 8.
- freeze_i high across an up pulse, then release with button still held -> no change; a new press then increments.
- up_i[0] held high through reset release -> stays 0. Load with load_val_i = 120 -> 99. Load with load_ch_i = 3 (NUM_CH=2) -> no change. clr_i concurrent with load -> all 0. rst_n_i low mid-count -> 0 asynchronously.
